// File: rtl/branch_pc_ctrl.sv
// Fetch-side PC sequencer: decodes ID-stage control flow, resolves branches/jumps,
// holds on unready operands and keeps saturating branch statistics.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       rs_val,
  input  logic              opnd_wait,
  input  logic              stall_in,
  input  logic              branch_used,
  output logic [2:0]        cmpctr,
  output logic [31:0]       pc,
  output logic              pc_hold,
  output logic              flush_ifid,
  output logic              link_en,
  output logic [31:0]       link_addr,
  output logic              addr_err,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  typedef enum logic [0:0] {S_RUN, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic              addr_err_q, addr_err_d;

  logic [5:0]        op, funct;
  logic [4:0]        rt;
  logic              is_cond, is_jimm, is_jreg, is_link;
  logic [2:0]        cmp_code;
  logic [31:0]       id_pc_plus4, br_tgt, j_tgt, jr_tgt, target;
  logic              hold, resolve, taken;

  assign op    = id_instr[31:26];
  assign rt    = id_instr[20:16];
  assign funct = id_instr[5:0];

  // Control-flow decode; nothing is recognised without id_valid
  always_comb begin
    is_cond  = 1'b0;
    is_jimm  = 1'b0;
    is_jreg  = 1'b0;
    is_link  = 1'b0;
    cmp_code = 3'b000;
    if (id_valid) begin
      unique case (op)
        OP_BEQ:  begin is_cond = 1'b1; cmp_code = 3'b000; end
        OP_BNE:  begin is_cond = 1'b1; cmp_code = 3'b001; end
        OP_BGTZ: begin is_cond = 1'b1; cmp_code = 3'b011; end
        OP_BLEZ: begin is_cond = 1'b1; cmp_code = 3'b100; end
        OP_REGIMM: begin
          unique case (rt)
            RT_BGEZ:   begin is_cond = 1'b1; cmp_code = 3'b010; end
            RT_BLTZ:   begin is_cond = 1'b1; cmp_code = 3'b101; end
            RT_BGEZAL: begin is_cond = 1'b1; cmp_code = 3'b110; is_link = 1'b1; end
            RT_BLTZAL: begin is_cond = 1'b1; cmp_code = 3'b111; is_link = 1'b1; end
            default:   ;
          endcase
        end
        OP_J:   is_jimm = 1'b1;
        OP_JAL: begin is_jimm = 1'b1; is_link = 1'b1; end
        OP_SPECIAL: begin
          if (funct == FN_JR)   is_jreg = 1'b1;
          if (funct == FN_JALR) begin is_jreg = 1'b1; is_link = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;
  assign br_tgt      = id_pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign j_tgt       = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
  assign jr_tgt      = {rs_val[31:2], 2'b00};
  assign target      = is_jreg ? jr_tgt : (is_jimm ? j_tgt : br_tgt);
  assign taken       = (is_cond && branch_used) || is_jimm || is_jreg;

  // Next-state, PC and statistics
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    addr_err_d  = 1'b0;
    hold        = 1'b0;
    resolve     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if ((is_cond || is_jreg) && opnd_wait) begin
          state_d = S_HOLD;
          hold    = 1'b1;
        end else if (stall_in) begin
          hold = 1'b1;
        end else begin
          resolve = 1'b1;
        end
      end
      S_HOLD: begin
        if (opnd_wait || stall_in) begin
          hold = 1'b1;
        end else begin
          resolve = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (resolve) begin
      pc_d       = taken ? target : pc_q + 32'd4;
      addr_err_d = is_jreg && (rs_val[1:0] != 2'b00);
      if (is_cond) begin
        if (br_cnt_q != {CNT_W{1'b1}}) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (branch_used && taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Redirect/hold/link strobes are suppressed while reset is held
  assign cmpctr     = cmp_code;
  assign pc         = pc_q;
  assign pc_hold    = rst_n && hold;
  assign flush_ifid = rst_n && resolve && taken;
  assign link_en    = rst_n && resolve && is_link;
  assign link_addr  = id_pc_plus4;
  assign addr_err   = addr_err_q;
  assign br_cnt     = br_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Bench for branch_pc_ctrl: directed scenarios plus randomized traffic against
// an instruction-level reference model.
module tb_branch_pc_ctrl;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0, id_valid = 1'b0, opnd_wait = 1'b0, stall_in = 1'b0, branch_used = 1'b0;
  logic [31:0]      id_instr = '0, id_pc = '0, rs_val = '0;
  logic [2:0]       cmpctr;
  logic [31:0]      pc, link_addr;
  logic             pc_hold, flush_ifid, link_en, addr_err;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pc_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rs_val(rs_val), .opnd_wait(opnd_wait), .stall_in(stall_in), .branch_used(branch_used),
    .cmpctr(cmpctr), .pc(pc), .pc_hold(pc_hold), .flush_ifid(flush_ifid), .link_en(link_en),
    .link_addr(link_addr), .addr_err(addr_err), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc = '0;
  bit          m_pending = 1'b0;
  int          m_br = 0, m_tk = 0;
  bit          m_err = 1'b0;
  bit          r_resolve, r_taken, r_cond, r_jreg, r_needs;
  logic [31:0] r_target;
  // Expected and observed mid-cycle outputs
  logic [2:0]  e_cmp, o_cmp;
  logic        e_hold, e_flush, e_link, o_hold, o_flush, o_link;
  logic [31:0] e_laddr, o_laddr;

  function automatic int code_of(logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rt;
    op = ins[31:26];
    rt = ins[20:16];
    if (op == 6'd4) return 0;
    if (op == 6'd5) return 1;
    if (op == 6'd7) return 3;
    if (op == 6'd6) return 4;
    if (op == 6'd1 && rt == 5'd1)  return 2;
    if (op == 6'd1 && rt == 5'd0)  return 5;
    if (op == 6'd1 && rt == 5'd17) return 6;
    if (op == 6'd1 && rt == 5'd16) return 7;
    return -1;
  endfunction

  task automatic model_comb();
    int code;
    bit jimm, lnk, hold;
    logic [31:0] off;
    code    = id_valid ? code_of(id_instr) : -1;
    r_cond  = (code >= 0);
    jimm    = id_valid && (id_instr[31:26] == 6'd2 || id_instr[31:26] == 6'd3);
    r_jreg  = id_valid && id_instr[31:26] == 6'd0 && (id_instr[5:0] == 6'd8 || id_instr[5:0] == 6'd9);
    lnk     = (id_valid && id_instr[31:26] == 6'd3) || (r_jreg && id_instr[5:0] == 6'd9) || code == 6 || code == 7;
    r_needs = r_cond || r_jreg;
    if (m_pending) hold = opnd_wait || stall_in;
    else           hold = (r_needs && opnd_wait) || stall_in;
    r_resolve = rst_n && !hold;
    r_taken   = (r_cond && branch_used) || jimm || r_jreg;
    off = {{16{id_instr[15]}}, id_instr[15:0]};
    if (r_jreg)    r_target = rs_val & ~32'd3;
    else if (jimm) r_target = ((id_pc + 32'd4) & 32'hF000_0000) | {4'd0, id_instr[25:0], 2'b00};
    else           r_target = id_pc + 32'd4 + off * 32'd4;
    e_cmp   = r_cond ? 3'(code) : 3'd0;
    e_hold  = rst_n && hold;
    e_flush = r_resolve && r_taken;
    e_link  = r_resolve && lnk;
    e_laddr = id_pc + 32'd4;
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      m_pc = RESET_PC; m_pending = 1'b0; m_br = 0; m_tk = 0; m_err = 1'b0;
    end else if (r_resolve) begin
      m_pc = r_taken ? r_target : m_pc + 32'd4;
      if (r_cond && m_br < CNT_MAX) m_br++;
      if (r_cond && r_taken && m_tk < CNT_MAX) m_tk++;
      m_err = r_jreg && (rs_val[1:0] != 2'b00);
      m_pending = 1'b0;
    end else begin
      m_err = 1'b0;
      m_pending = m_pending || (r_needs && opnd_wait);
    end
  endtask

  // One clock: sample combinational outputs mid-cycle, then advance past the edge
  task automatic tick();
    #4;
    model_comb();
    o_cmp = cmpctr; o_hold = pc_hold; o_flush = flush_ifid; o_link = link_en; o_laddr = link_addr;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  task automatic idle();
    id_valid = 1'b0; id_instr = '0; opnd_wait = 1'b0; stall_in = 1'b0; branch_used = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; tick(); tick();
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp 00003000", pc); end
    n_tests++; if ({o_hold, o_flush, o_link, addr_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {o_hold, o_flush, o_link, addr_err}); end
    n_tests++; if (br_cnt !== '0 || taken_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", br_cnt, taken_cnt); end
    rst_n = 1'b1; tick();
    n_tests++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL release_pc1 got %h exp 00003004", pc); end
    tick();
    n_tests++; if (pc !== 32'h3008 || pc !== m_pc) begin n_fail++; $display("FAIL release_pc2 got %h exp 00003008", pc); end
    n_tests++; if ({o_hold, o_flush, o_link} !== 3'b0) begin n_fail++; $display("FAIL release_flags got %b exp 000", {o_hold, o_flush, o_link}); end
  endtask

  task automatic test_beq_taken();
    do_reset();
    id_valid = 1'b1; id_pc = 32'h3010; id_instr = mk_i(6'd4, 5'd4, 16'hFFFC); branch_used = 1'b1;
    tick();
    n_tests++; if (o_cmp !== 3'b000) begin n_fail++; $display("FAIL beq_cmp got %b exp 000", o_cmp); end
    n_tests++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush got %b exp 1", o_flush); end
    n_tests++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL beq_pc got %h exp 00003004", pc); end
    n_tests++; if (br_cnt !== 4'd1 || taken_cnt !== 4'd1) begin n_fail++; $display("FAIL beq_cnt got %0d/%0d exp 1/1", br_cnt, taken_cnt); end
    idle();
  endtask

  task automatic test_bne_hold();
    do_reset();
    id_valid = 1'b1; id_pc = 32'h3000; id_instr = mk_i(6'd5, 5'd4, 16'h0010); opnd_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (o_hold !== 1'b1 || o_flush !== 1'b0) begin n_fail++; $display("FAIL bne_hold%0d got hold=%b flush=%b exp 1/0", i, o_hold, o_flush); end
      n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL bne_frozen%0d got %h exp 00003000", i, pc); end
    end
    opnd_wait = 1'b0; branch_used = 1'b0;
    tick();
    n_tests++; if (o_hold !== 1'b0 || o_flush !== 1'b0 || o_cmp !== 3'b001) begin n_fail++; $display("FAIL bne_resolve got hold=%b flush=%b cmp=%b exp 0/0/001", o_hold, o_flush, o_cmp); end
    n_tests++; if (pc !== 32'h3004 || br_cnt !== 4'd1 || taken_cnt !== 4'd0) begin n_fail++; $display("FAIL bne_after got pc=%h cnt=%0d/%0d exp 00003004 1/0", pc, br_cnt, taken_cnt); end
    idle();
  endtask

  task automatic test_jalr();
    do_reset();
    id_valid = 1'b1; id_pc = 32'h3020; rs_val = 32'h0000_4002; id_instr = {6'd0, 5'd7, 5'd0, 5'd31, 5'd0, 6'd9};
    tick();
    n_tests++; if (o_flush !== 1'b1 || o_link !== 1'b1) begin n_fail++; $display("FAIL jalr_flags got flush=%b link=%b exp 1/1", o_flush, o_link); end
    n_tests++; if (o_laddr !== 32'h3024) begin n_fail++; $display("FAIL jalr_laddr got %h exp 00003024", o_laddr); end
    n_tests++; if (pc !== 32'h4000 || addr_err !== 1'b1) begin n_fail++; $display("FAIL jalr_pc got pc=%h err=%b exp 00004000/1", pc, addr_err); end
    idle();
    tick();
    n_tests++; if (addr_err !== 1'b0 || pc !== 32'h4004) begin n_fail++; $display("FAIL jalr_err_pulse got err=%b pc=%h exp 0/00004004", addr_err, pc); end
  endtask

  task automatic test_bltzal_stall();
    do_reset();
    id_valid = 1'b1; id_pc = 32'h3000; id_instr = mk_i(6'd1, 5'd16, 16'h0040); stall_in = 1'b1; branch_used = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (o_cmp !== 3'b111 || o_link !== 1'b0 || o_hold !== 1'b1) begin n_fail++; $display("FAIL bltzal_stall%0d got cmp=%b link=%b hold=%b exp 111/0/1", i, o_cmp, o_link, o_hold); end
    end
    n_tests++; if (br_cnt !== 4'd0 || pc !== 32'h3000) begin n_fail++; $display("FAIL bltzal_nocount got cnt=%0d pc=%h exp 0/00003000", br_cnt, pc); end
    stall_in = 1'b0;
    tick();
    n_tests++; if (o_link !== 1'b1 || o_flush !== 1'b0) begin n_fail++; $display("FAIL bltzal_resolve got link=%b flush=%b exp 1/0", o_link, o_flush); end
    idle();
    tick();
    n_tests++; if (br_cnt !== 4'd1 || taken_cnt !== 4'd0 || pc !== 32'h3008) begin n_fail++; $display("FAIL bltzal_once got cnt=%0d/%0d pc=%h exp 1/0/00003008", br_cnt, taken_cnt, pc); end
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1'b1; id_pc = 32'h3000; id_instr = mk_i(6'd7, 5'd0, 16'h0004); branch_used = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    n_tests++; if (br_cnt !== 4'd15 || taken_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 15/15", br_cnt, taken_cnt); end
    opnd_wait = 1'b1;
    tick(); tick();
    n_tests++; if (o_hold !== 1'b1 || br_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got hold=%b cnt=%0d exp 1/15", o_hold, br_cnt); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (o_hold !== 1'b0 || o_flush !== 1'b0 || o_link !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold_flags got %b%b%b exp 000", o_hold, o_flush, o_link); end
    n_tests++; if (pc !== 32'h3000 || br_cnt !== 4'd0 || taken_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_hold_state got pc=%h cnt=%0d/%0d exp 00003000 0/0", pc, br_cnt, taken_cnt); end
    rst_n = 1'b1; id_valid = 1'b0;
    tick();
    n_tests++; if (o_hold !== 1'b0 || pc !== 32'h3004) begin n_fail++; $display("FAIL rst_back_to_run got hold=%b pc=%h exp 0/00003004", o_hold, pc); end
    idle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 13))
      0:  return {6'd4, r[25:0]};
      1:  return {6'd5, r[25:0]};
      2:  return {6'd7, r[25:0]};
      3:  return {6'd6, r[25:0]};
      4:  return {6'd1, r[25:21], 5'd1,  r[15:0]};
      5:  return {6'd1, r[25:21], 5'd0,  r[15:0]};
      6:  return {6'd1, r[25:21], 5'd17, r[15:0]};
      7:  return {6'd1, r[25:21], 5'd16, r[15:0]};
      8:  return {6'd2, r[25:0]};
      9:  return {6'd3, r[25:0]};
      10: return {6'd0, r[25:6], 6'd8};
      11: return {6'd0, r[25:6], 6'd9};
      12: return {6'd9, r[25:0]};
      default: return {6'd0, r[25:6], 6'h20};
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if (!m_pending || $urandom_range(0, 5) == 0) begin
        id_valid = ($urandom_range(0, 4) != 0);
        id_instr = rand_instr();
        id_pc    = $urandom() & 32'hFFFF_FFFC;
        rs_val   = $urandom();
      end
      opnd_wait   = ($urandom_range(0, 3) == 0);
      stall_in    = ($urandom_range(0, 4) == 0);
      branch_used = 1'($urandom_range(0, 1));
      tick();
      n_tests++; if ({o_cmp, o_hold, o_flush, o_link} !== {e_cmp, e_hold, e_flush, e_link}) begin n_fail++; $display("FAIL rnd_comb[%0d] got cmp=%b h=%b f=%b l=%b exp cmp=%b h=%b f=%b l=%b", i, o_cmp, o_hold, o_flush, o_link, e_cmp, e_hold, e_flush, e_link); end
      n_tests++; if (o_laddr !== e_laddr) begin n_fail++; $display("FAIL rnd_laddr[%0d] got %h exp %h", i, o_laddr, e_laddr); end
      n_tests++; if (pc !== m_pc || addr_err !== m_err) begin n_fail++; $display("FAIL rnd_pc[%0d] got pc=%h err=%b exp %h/%b", i, pc, addr_err, m_pc, m_err); end
      n_tests++; if (br_cnt !== CNT_W'(m_br) || taken_cnt !== CNT_W'(m_tk)) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", i, br_cnt, taken_cnt, m_br, m_tk); end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_hold();
    test_jalr();
    test_bltzal_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
Fetch-side branch resolution and PC sequencing unit for the MIPS pipeline. It decodes the ID-stage control-flow instruction into the 3-bit compare code for the ID-stage branch comparator, then consumes the comparator's taken result (branch_used). It computes branch, jump and register targets and owns the PC register. It also drives the IF/ID flush, the hold for unready branch operands, the link request, and saturating branch statistics. The architecture has no delay slot, so a taken redirect flushes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded at reset.
CNT_W, 16, width of saturating statistics counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
id_valid  in  1  ID stage holds a valid instruction.
id_instr  in  32  ID-stage instruction word.
id_pc  in  32  PC of the ID-stage instruction.
rs_val  in  32  forwarded rs value, used as the jr/jalr target.
opnd_wait  in  1  branch/jr operands not yet forwardable (load-use).
stall_in  in  1  external pipeline stall; freezes the PC.
branch_used  in  1  comparator taken result for the current cmpctr.
cmpctr  out  3  compare code to the comparator.
pc  out  32  current fetch PC (registered).
pc_hold  out  1  IF must not advance this cycle.
flush_ifid  out  1  clear IF/ID at this clock edge.
link_en  out  1  write link register this cycle.
link_addr  out  32  id_pc+4.
addr_err  out  1  one-cycle registered pulse on a misaligned jr/jalr target.
br_cnt  out  CNT_W  conditional branches resolved.
taken_cnt  out  CNT_W  conditional branches taken.

Behaviour:
- Decode, combinational:
  - beq 000100 -> cmpctr 000.
  - bne 000101 -> 001.
  - REGIMM 000001 with rt 00001 (bgez) -> 010.
  - bgtz 000111 -> 011.
  - blez 000110 -> 100.
  - REGIMM rt 00000 (bltz) -> 101.
  - REGIMM rt 10001 (bgezal) -> 110.
  - REGIMM rt 10000 (bltzal) -> 111.
  - cmpctr is 000 for non-branches. A branch is only recognised when id_valid=1.
- Jumps: j 000010, jal 000011, SPECIAL funct 001000 jr, 001001 jalr.
- Targets, all mod 2^32:
  - Branch target = id_pc + 4 + (sext(imm16) << 2).
  - j/jal target = {(id_pc+4)[31:28], instr_index, 2'b00}.
  - jr/jalr target = {rs_val[31:2], 2'b00}. Nonzero rs_val[1:0] asserts addr_err the following cycle.
- States: RUN, HOLD. Reset -> RUN.
- RUN:
  - Condition: id_valid, the instruction is a conditional branch or jr/jalr, and opnd_wait=1. Effect: go to HOLD; pc held; pc_hold=1; no flush; no counter update.
  - Else, if stall_in=1: pc held, pc_hold=1, nothing resolved. The decision is re-evaluated next cycle and counted once only.
  - Else, resolve:
    - Taken means a conditional branch with branch_used=1, or any jump.
    - On taken: pc<=target and flush_ifid=1 in the same cycle (combinational, gated by the resolve condition).
    - Not taken or no control flow: pc<=pc+4.
    - Conditional branch: br_cnt+1; taken_cnt+1 if taken.
- HOLD:
  - pc_hold=1 while opnd_wait=1 or stall_in=1.
  - When both are low, resolve exactly as in RUN and return to RUN. A HOLD-exit resolve counts once.
- link_en=1 in the resolving cycle for jal and jalr always, and for bgezal/bltzal regardless of taken.
- Counters saturate at all-ones and never wrap.
- Reset while rst_n=0 at a clock edge:
  - pc=RESET_PC, state RUN, counters 0, addr_err 0.
  - flush_ifid, link_en and pc_hold are forced 0 while rst_n=0, including mid-HOLD.
- Reset during HOLD discards the pending branch.

Test Plan:
- Reset release: rst_n low 2 cycles, no instructions -> pc=0x3000, then 0x3004, 0x3008; all flags 0; counters 0.
- beq taken: id_pc=0x3010, imm16=0xFFFC, branch_used=1 -> cmpctr=000, flush_ifid=1, next pc=0x3004, br_cnt=1, taken_cnt=1.
- bne not taken with opnd_wait high 2 cycles: -> pc_hold=1 for 2 cycles, pc frozen, then pc+4, br_cnt=1, taken_cnt=0.
- jalr with rs_val=0x0000_4002 at id_pc=0x3020 -> pc=0x4000, flush_ifid=1, link_en=1, link_addr=0x3024, addr_err pulses 1 cycle.
- bltzal not taken under stall_in for 3 cycles -> cmpctr=111, link_en asserted only in the resolve cycle, br_cnt increments exactly once.
- Saturation: CNT_W=4, 17 taken bgtz -> br_cnt=taken_cnt=15 held. Reset asserted mid-HOLD -> pc=0x3000, state RUN.
